// File: rtl/aes_decrypt_iterative.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iterative
//   Iterative AES inverse cipher (FIPS-197 InvCipher). One block is in flight
//   at a time. The block runs one inverse round per clock and uses
//   keyExpansion for the combinational round-key schedule.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    ct_in/key_in valid
//   in_ready   out  1    block can accept a new input (IDLE)
//   ct_in      in   128  ciphertext, byte 0 in [127:120]
//   key_in     in   N    cipher key, byte 0 in MSBs
//   out_valid  out  1    pt_out holds a finished plaintext (DONE)
//   out_ready  in   1    downstream accepts pt_out
//   pt_out     out  128  plaintext, zero outside DONE
//
// keyExpansion
//   i_key          in   32*Nk           cipher key, word 0 in MSBs
//   o_round_keys   out  128*(Nr+1)      round key i at [top - 128*i -: 128]
// ---------------------------------------------------------------------------

package aes_decrypt_iterative_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (bits 1..7 of the exponent set); 0 maps to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        y = ginv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] y;
        y = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
        return ginv(y);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

module keyExpansion
    import aes_decrypt_iterative_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic [32*Nk-1:0]      i_key,
    output logic [128*(Nr+1)-1:0] o_round_keys
);

    localparam int unsigned NK_U = Nk;
    localparam int unsigned NW   = 4 * (Nr + 1);
    localparam int unsigned TOP  = 128 * (Nr + 1) - 1;

    // Rcon is tracked incrementally instead of being tabled.
    function automatic logic [128*(Nr+1)-1:0] expand(input logic [32*Nk-1:0] k);
        logic [31:0]           w [NW];
        logic [31:0]           t;
        logic [7:0]            rc;
        logic [128*(Nr+1)-1:0] o;
        rc = 8'h01;
        for (int unsigned i = 0; i < NK_U; i++) begin
            w[i] = k[32*NK_U-1 - 32*i -: 32];
        end
        for (int unsigned i = NK_U; i < NW; i++) begin
            t = w[i-1];
            if (i % NK_U == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (NK_U > 6 && i % NK_U == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-NK_U] ^ t;
        end
        for (int unsigned i = 0; i < NW; i++) begin
            o[TOP - 32*i -: 32] = w[i];
        end
        return o;
    endfunction

    assign o_round_keys = expand(i_key);

endmodule

module aes_decrypt_iterative
    import aes_decrypt_iterative_pkg::*;
#(
    parameter int N  = 128,
    parameter int Nr = 10,
    parameter int Nk = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    input  logic [N-1:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out
);

    localparam int unsigned NR_U = Nr;
    localparam int unsigned TOP  = 128 * (Nr + 1) - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                r_fsm;
    state_t                w_fsm_nxt;
    logic [N-1:0]          r_key;
    logic [127:0]          r_state;
    logic [3:0]            r_round;

    logic [128*(Nr+1)-1:0] w_rk_all;
    logic [127:0]          w_rk_cur;
    logic [127:0]          w_inv_core;
    logic [127:0]          w_round_out;

    // State byte b = 4*col + row, byte 0 in the MSBs.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned b = 0; b < 16; b++) begin
            o[127 - 8*b -: 8] = inv_sbox(s[127 - 8*b -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c      -: 8];
            a1 = s[127 - 32*c - 8  -: 8];
            a2 = s[127 - 32*c - 16 -: 8];
            a3 = s[127 - 32*c - 24 -: 8];
            o[127 - 32*c      -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[127 - 32*c - 8  -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[127 - 32*c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[127 - 32*c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    keyExpansion #(
        .Nk (Nk),
        .Nr (Nr)
    ) u_key_exp (
        .i_key        (r_key),
        .o_round_keys (w_rk_all)
    );

    always_comb begin
        w_rk_cur = '0;
        for (int unsigned i = 0; i <= NR_U; i++) begin
            if (r_round == 4'(i)) w_rk_cur = w_rk_all[TOP - 128*i -: 128];
        end
    end

    // AddRoundKey precedes InvMixColumns; the last round skips InvMixColumns.
    assign w_inv_core  = inv_sub_bytes(inv_shift_rows(r_state)) ^ w_rk_cur;
    assign w_round_out = (r_round == '0) ? w_inv_core : inv_mix_columns(w_inv_core);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (in_valid)        w_fsm_nxt = S_INIT;
            S_INIT:                       w_fsm_nxt = S_ROUND;
            S_ROUND: if (r_round == '0)   w_fsm_nxt = S_DONE;
            S_DONE:  if (out_ready)       w_fsm_nxt = S_IDLE;
            default:                      w_fsm_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    assign pt_out    = (r_fsm == S_DONE) ? r_state : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= ct_in;
                        r_key   <= key_in;
                    end
                end
                S_INIT: begin
                    r_state <= r_state ^ w_rk_all[127:0];
                    r_round <= 4'(Nr - 1);
                end
                S_ROUND: begin
                    r_state <= w_round_out;
                    if (r_round != '0) r_round <= r_round - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
